// File: rtl/ula_pkg.sv
// Shared definitions for the ula execute controller: widths, opcodes, FSM encoding.
// Latency: not applicable, this file holds declarations only.
// Backpressure: not applicable.
package ula_pkg;

  localparam int W     = 8;
  localparam int NREGS = 4;

  localparam logic [3:0] OP_NOT = 4'd0;
  localparam logic [3:0] OP_AND = 4'd1;
  localparam logic [3:0] OP_OR  = 4'd2;
  localparam logic [3:0] OP_XOR = 4'd3;
  localparam logic [3:0] OP_ADD = 4'd4;
  localparam logic [3:0] OP_SUB = 4'd5;
  localparam logic [3:0] OP_SLR = 4'd6;
  localparam logic [3:0] OP_SRR = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_ROL = 4'd9;
  localparam logic [3:0] OP_MOV = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_e;

  // True for opcodes whose result comes from the ula and updates the ZERO flag.
  function automatic logic is_alu_op(input logic [3:0] op);
    case (op)
      OP_NOT, OP_AND, OP_OR, OP_XOR, OP_ADD,
      OP_SUB, OP_SLR, OP_SRR, OP_MUL, OP_ROL: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ula_ctrl_if.sv
// Bundle of the controller's instruction, load, ula and debug signals.
// Latency: wires only, no storage.
// Backpressure: instr_valid/instr_ready handshake; ld and ula signals have none.
interface ula_ctrl_if;
  import ula_pkg::*;

  logic         instr_valid;
  logic         instr_ready;
  logic [W-1:0] instr;
  logic         ld_valid;
  logic [1:0]   ld_addr;
  logic [W-1:0] ld_data;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [3:0]   alu_sel;
  logic [W-1:0] alu_s;
  logic         alu_zero;
  logic         done;
  logic         err;
  logic         zero_flag;
  logic [1:0]   dbg_addr;
  logic [W-1:0] dbg_data;

  // Environment side: issues instructions/loads, hosts the ula, reads debug.
  modport master (
    output instr_valid, instr, ld_valid, ld_addr, ld_data, alu_s, alu_zero, dbg_addr,
    input  instr_ready, alu_a, alu_b, alu_sel, done, err, zero_flag, dbg_data
  );

  // Controller side.
  modport slave (
    input  instr_valid, instr, ld_valid, ld_addr, ld_data, alu_s, alu_zero, dbg_addr,
    output instr_ready, alu_a, alu_b, alu_sel, done, err, zero_flag, dbg_data
  );

endinterface

// File: rtl/ula_regfile.sv
// 4x8 register file: one write port, two operand read ports and one debug read port.
// Latency: reads are combinational; a write is visible the cycle after its edge.
// Backpressure: none, a write with we=1 always lands.
module ula_regfile
  import ula_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         we,
  input  logic [1:0]   waddr,
  input  logic [W-1:0] wdata,
  input  logic [1:0]   ra_addr,
  input  logic [1:0]   rb_addr,
  input  logic [1:0]   dbg_addr,
  output logic [W-1:0] ra_data,
  output logic [W-1:0] rb_data,
  output logic [W-1:0] dbg_data
);

  logic [W-1:0] mem_q [NREGS];
  logic [W-1:0] mem_d [NREGS];

  // Next contents: unchanged unless the single write port targets an entry.
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  // Storage clears to zero on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign ra_data  = mem_q[ra_addr];
  assign rb_data  = mem_q[rb_addr];
  assign dbg_data = mem_q[dbg_addr];

endmodule

// File: rtl/ula_ctrl.sv
// Four-state execute controller driving the combinational ula from a 4x8 register file.
// Latency: accepted at edge N, done pulses in the WB cycle before edge N+3; one op per 4 cycles.
// Backpressure: instr_ready is high only in IDLE; loads outside IDLE are dropped.
module ula_ctrl
  import ula_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  ula_ctrl_if.slave  bus
);

  state_e       state_q, state_d;
  logic [W-1:0] ir_q, ir_d;
  logic [W-1:0] alu_a_q, alu_a_d;
  logic [W-1:0] alu_b_q, alu_b_d;
  logic [3:0]   alu_sel_q, alu_sel_d;
  logic [W-1:0] res_q, res_d;
  logic         zf_q, zf_d;
  logic         zero_flag_q, zero_flag_d;

  logic         rf_we;
  logic [1:0]   rf_waddr;
  logic [W-1:0] rf_wdata;
  logic [W-1:0] rd_a, rd_b;

  logic [3:0]   opcode;
  logic [1:0]   ra, rb;

  assign opcode = ir_q[7:4];
  assign ra     = ir_q[3:2];
  assign rb     = ir_q[1:0];

  ula_regfile u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (rf_we),
    .waddr    (rf_waddr),
    .wdata    (rf_wdata),
    .ra_addr  (ra),
    .rb_addr  (rb),
    .dbg_addr (bus.dbg_addr),
    .ra_data  (rd_a),
    .rb_data  (rd_b),
    .dbg_data (bus.dbg_data)
  );

  // Sequencing plus the register-file write mux (direct load in IDLE, writeback in WB).
  always_comb begin
    state_d         = state_q;
    ir_d            = ir_q;
    alu_a_d         = alu_a_q;
    alu_b_d         = alu_b_q;
    alu_sel_d       = alu_sel_q;
    res_d           = res_q;
    zf_d            = zf_q;
    zero_flag_d     = zero_flag_q;
    rf_we           = 1'b0;
    rf_waddr        = 2'd0;
    rf_wdata        = '0;
    bus.instr_ready = 1'b0;
    bus.done        = 1'b0;
    bus.err         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bus.instr_ready = 1'b1;
        // The load writes at the same edge the instruction is latched, so READ sees it.
        if (bus.ld_valid) begin
          rf_we    = 1'b1;
          rf_waddr = bus.ld_addr;
          rf_wdata = bus.ld_data;
        end
        if (bus.instr_valid) begin
          ir_d    = bus.instr;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        alu_a_d   = rd_a;
        alu_b_d   = rd_b;
        alu_sel_d = (is_alu_op(opcode) || opcode == OP_MOV) ? opcode : 4'd0;
        state_d   = ST_EXEC;
      end
      ST_EXEC: begin
        res_d   = bus.alu_s;
        zf_d    = bus.alu_zero;
        state_d = ST_WB;
      end
      ST_WB: begin
        bus.done = 1'b1;
        if (is_alu_op(opcode)) begin
          rf_we       = 1'b1;
          rf_waddr    = ra;
          rf_wdata    = res_q;
          zero_flag_d = zf_q;
        end else if (opcode == OP_MOV) begin
          rf_we    = 1'b1;
          rf_waddr = ra;
          rf_wdata = rd_b;
        end else begin
          bus.err = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any in-flight instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ir_q        <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      res_q       <= '0;
      zf_q        <= 1'b0;
      zero_flag_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      res_q       <= res_d;
      zf_q        <= zf_d;
      zero_flag_q <= zero_flag_d;
    end
  end

  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_sel   = alu_sel_q;
  assign bus.zero_flag = zero_flag_q;

endmodule

// File: tb/tb_ula_ctrl.sv
// Testbench for ula_ctrl: hosts a behavioural ula and checks against a register-array model.
// Latency: expects done in the third cycle after acceptance and writes visible one cycle later.
// Backpressure: issues instructions only while instr_ready is sampled high.
module tb_ula_ctrl;
  import ula_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  logic [7:0] ref_r [4];
  logic       ref_zf;

  ula_ctrl_if bus ();

  ula_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] t;
    logic [15:0] p;
    case (op)
      4'd0: return ~a;
      4'd1: return a & b;
      4'd2: return a | b;
      4'd3: return a ^ b;
      4'd4: return a + b;
      4'd5: return a - b;
      4'd6: return a << 1;
      4'd7: return a >> 1;
      4'd8: begin p = a * b; return p[7:0]; end
      4'd9: begin t = {a, a} << (b % 8); return t[15:8]; end
      default: return 8'h00;
    endcase
  endfunction

  // Behavioural ula sitting behind the controller.
  always_comb begin
    bus.alu_s    = alu_f(bus.alu_sel, bus.alu_a, bus.alu_b);
    bus.alu_zero = (bus.alu_s == 8'h00);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 4; i++) begin
      bus.dbg_addr = i[1:0];
      #1;
      chk($sformatf("%s_r%0d", tag, i), {24'd0, bus.dbg_data}, {24'd0, ref_r[i]});
    end
  endtask

  task automatic model_exec(input logic [7:0] ins, output logic exp_err);
    logic [3:0] op;
    logic [7:0] a, b, s;
    op = ins[7:4];
    a = ref_r[ins[3:2]];
    b = ref_r[ins[1:0]];
    exp_err = 1'b0;
    if (op <= 4'd9) begin
      s = alu_f(op, a, b);
      ref_r[ins[3:2]] = s;
      ref_zf = (s == 8'h00);
    end else if (op == 4'd10) begin
      ref_r[ins[3:2]] = b;
    end else begin
      exp_err = 1'b1;
    end
  endtask

  task automatic do_load(input logic [1:0] addr, input logic [7:0] data);
    bus.ld_valid = 1'b1;
    bus.ld_addr  = addr;
    bus.ld_data  = data;
    @(posedge clk); #1;
    bus.ld_valid = 1'b0;
    ref_r[addr] = data;
  endtask

  // ld_mode: 0 none, 1 load together with acceptance, 2 load pulsed during EXEC (dropped).
  task automatic run_instr(input logic [7:0] ins, input int ld_mode, input logic [1:0] la, input logic [7:0] ld);
    logic exp_err;
    chk("ready_idle", {31'd0, bus.instr_ready}, 32'd1);
    bus.instr = ins;
    bus.instr_valid = 1'b1;
    if (ld_mode == 1) begin
      bus.ld_valid = 1'b1;
      bus.ld_addr  = la;
      bus.ld_data  = ld;
      ref_r[la] = ld;
    end
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    bus.ld_valid = 1'b0;
    chk("ready_busy", {31'd0, bus.instr_ready}, 32'd0);
    chk("done_read", {31'd0, bus.done}, 32'd0);
    @(posedge clk); #1;
    chk("done_exec", {31'd0, bus.done}, 32'd0);
    if (ld_mode == 2) begin
      bus.ld_valid = 1'b1;
      bus.ld_addr  = la;
      bus.ld_data  = ld;
    end
    @(posedge clk); #1;
    bus.ld_valid = 1'b0;
    model_exec(ins, exp_err);
    chk("done_wb", {31'd0, bus.done}, 32'd1);
    chk("err_wb", {31'd0, bus.err}, {31'd0, exp_err});
    @(posedge clk); #1;
    chk("done_after", {31'd0, bus.done}, 32'd0);
    chk("zero_flag", {31'd0, bus.zero_flag}, {31'd0, ref_zf});
    check_regs($sformatf("ins%02h", ins));
  endtask

  initial begin
    logic [7:0] ri;
    bus.instr_valid = 1'b0;
    bus.instr       = 8'h00;
    bus.ld_valid    = 1'b0;
    bus.ld_addr     = 2'd0;
    bus.ld_data     = 8'h00;
    bus.dbg_addr    = 2'd0;
    for (int i = 0; i < 4; i++) ref_r[i] = 8'h00;
    ref_zf = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_err", {31'd0, bus.err}, 32'd0);
    chk("rst_zf", {31'd0, bus.zero_flag}, 32'd0);
    chk("rst_alu_a", {24'd0, bus.alu_a}, 32'd0);
    chk("rst_alu_b", {24'd0, bus.alu_b}, 32'd0);
    chk("rst_alu_sel", {28'd0, bus.alu_sel}, 32'd0);
    check_regs("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", {31'd0, bus.instr_ready}, 32'd1);

    // ADD R0,R1.
    do_load(2'd0, 8'h47);
    do_load(2'd1, 8'h02);
    run_instr(8'h41, 0, 2'd0, 8'h00);
    chk("add_val", {24'd0, ref_r[0]}, 32'h49);

    // SUB to zero, then NOT.
    do_load(2'd0, 8'h47);
    do_load(2'd2, 8'h47);
    run_instr(8'h52, 0, 2'd0, 8'h00);
    chk("sub_zf_model", {31'd0, ref_zf}, 32'd1);
    run_instr(8'h01, 0, 2'd0, 8'h00);

    // ROL by 12 (mod 8 = 4), then MUL.
    do_load(2'd0, 8'h47);
    do_load(2'd3, 8'h0C);
    run_instr(8'h93, 0, 2'd0, 8'h00);
    do_load(2'd0, 8'h47);
    do_load(2'd1, 8'h02);
    run_instr(8'h81, 0, 2'd0, 8'h00);

    // Illegal opcode, then MOV.
    run_instr(8'hF1, 0, 2'd0, 8'h00);
    run_instr(8'hA1, 0, 2'd0, 8'h00);

    // Load coinciding with acceptance; Ra==Rb.
    run_instr(8'h45, 1, 2'd1, 8'h81);

    // Continuous instr_valid: acceptance every 4th cycle.
    bus.instr = 8'h00;
    bus.instr_valid = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      chk($sformatf("stream_ready_%0d", k), {31'd0, bus.instr_ready}, {31'd0, (k % 4) == 3});
      chk($sformatf("stream_done_%0d", k), {31'd0, bus.done}, {31'd0, (k % 4) == 2});
      if (k == 11) bus.instr_valid = 1'b0;
    end
    for (int k = 0; k < 3; k++) begin
      ri = ~ref_r[0];
      ref_r[0] = ri;
      ref_zf = (ri == 8'h00);
    end
    chk("stream_zf", {31'd0, bus.zero_flag}, {31'd0, ref_zf});
    check_regs("stream");

    // Load pulsed during EXEC is dropped.
    run_instr(8'h41, 2, 2'd2, 8'h55);

    // Randomised instructions and loads.
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 1) == 1) do_load(2'($urandom_range(0, 3)), 8'($urandom));
      run_instr(8'($urandom), int'($urandom_range(0, 2)), 2'($urandom_range(0, 3)), 8'($urandom));
    end

    // Reset during EXEC of ADD aborts it.
    do_load(2'd0, 8'h10);
    chk("ready_pre_abort", {31'd0, bus.instr_ready}, 32'd1);
    bus.instr = 8'h41;
    bus.instr_valid = 1'b1;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) ref_r[i] = 8'h00;
    ref_zf = 1'b0;
    chk("abort_done", {31'd0, bus.done}, 32'd0);
    chk("abort_zf", {31'd0, bus.zero_flag}, 32'd0);
    chk("abort_alu_a", {24'd0, bus.alu_a}, 32'd0);
    check_regs("abort");
    @(posedge clk); #1;
    chk("abort_done2", {31'd0, bus.done}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_ready", {31'd0, bus.instr_ready}, 32'd1);
    chk("abort_done3", {31'd0, bus.done}, 32'd0);
    check_regs("abort_post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
